// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller. It requests one word at the PC, holds it
// in the instruction register until decode accepts it, then advances or redirects.
// Ports: clk, rst (async active-high); start/halt/redirect/redirect_pc control;
//   imem_req/imem_addr/imem_rdy/imem_rdata memory port; ir_valid/ir/ir_pc/dec_ready
//   decode port; busy status; fetch_cnt accepted-instruction count.
// Optional: define FETCH_PERF_CNT_EN to build the saturating fetch_cnt counter;
//   without it fetch_cnt is constant zero.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        halt,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rdy,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    output logic [31:0] ir,
    output logic [31:0] ir_pc,
    input  logic        dec_ready,
    output logic        busy,
    output logic [15:0] fetch_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] ir_pc_q, ir_pc_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 32'h0;
            ir_pc_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ir_pc_q <= ir_pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        ir_pc_d = ir_pc_q;
        unique case (state_q)
            S_IDLE: begin
                if (redirect) pc_d = redirect_pc;
                if (start) state_d = S_REQ;
            end
            S_REQ: begin
                // A redirect wins over returning data, so that data is dropped.
                if (redirect) begin
                    pc_d = redirect_pc;
                end else if (imem_rdy) begin
                    ir_d    = imem_rdata;
                    ir_pc_d = pc_q;
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                // Redirect overrides both the sequential PC and halt.
                if (redirect) begin
                    pc_d    = redirect_pc;
                    state_d = S_REQ;
                end else if (dec_ready) begin
                    pc_d    = pc_q + PC_STEP;
                    state_d = halt ? S_IDLE : S_REQ;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode directly from state so reset drops them immediately.
    assign imem_req  = (state_q == S_REQ);
    assign imem_addr = pc_q;
    assign ir_valid  = (state_q == S_HOLD);
    assign ir        = ir_q;
    assign ir_pc     = ir_pc_q;
    assign busy      = (state_q != S_IDLE);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt_q, cnt_d;
    logic        handoff;

    // A handoff counts even when a redirect arrives in the same cycle.
    assign handoff = (state_q == S_HOLD) && dec_ready;

    always_comb begin
        cnt_d = cnt_q;
        if (handoff && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'h0;
        else     cnt_q <= cnt_d;
    end

    assign fetch_cnt = cnt_q;
`else
    assign fetch_cnt = 16'h0000;
`endif

endmodule
